// File: rtl/alu_nzcv_writeback.sv
// Writeback/accumulator stage that sits behind the 4-bit NZCV ALU.
// Each accepted step press evaluates an ARM condition code against the stored
// flags. A passing step commits the staged ALU result, and optionally the staged
// flags. Executed and skipped steps are counted with saturation.
// Optional feature: define STEP_DEBOUNCE_EN to insert a level debouncer
// between the step synchronizer and the edge detector.
module alu_nzcv_writeback #(
    parameter int unsigned N               = 4,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_step,
    input  logic [3:0]       i_cond,
    input  logic             i_set_flags,
    input  logic [N-1:0]     i_res,
    input  logic [3:0]       i_nzcv,
    output logic [N-1:0]     o_acc,
    output logic [3:0]       o_nzcv,
    output logic             o_cond_pass,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_exec_cnt,
    output logic [CNT_W-1:0] o_skip_cnt
);

    typedef enum logic [1:0] {StIdle, StEval, StCommit, StWaitRel} state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             meta_q, sync_q, prev_q;
    logic [1:0]       settle_q;
    logic             step_lvl, step_edge;
    logic [N-1:0]     acc_q, res_q;
    logic [3:0]       nzcv_q, flags_q;
    logic             pass_q;
    logic [CNT_W-1:0] exec_q, skip_q;

    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    // Condition code evaluated against the stored flags {N, Z, C, V}.
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        unique case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Two-flop synchronizer for the raw key. settle_q marks when both stages
    // hold real post-reset samples, so a key held through reset is not seen
    // as released (and then as a fresh press) while the pipeline fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            settle_q <= 2'b00;
        end else begin
            meta_q   <= i_step;
            sync_q   <= meta_q;
            settle_q <= {settle_q[0], 1'b1};
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DbW-1:0] db_cnt_q;
    logic           db_lvl_q;

    // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive
    // cycles at the new value; any bounce back restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
        end else if (sync_q == db_lvl_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_q <= '0;
            db_lvl_q <= sync_q;
        end else begin
            db_cnt_q <= db_cnt_q + DbW'(1);
        end
    end

    assign step_lvl = db_lvl_q;
`else
    assign step_lvl = sync_q;
`endif

    assign step_edge = step_lvl & ~prev_q;

    // Control state and edge-detector history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWaitRel;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= step_lvl;
        end
    end

    // Next-state logic; edges outside StIdle are dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (step_edge) state_d = StEval;
            StEval:    state_d = StCommit;
            StCommit:  state_d = StWaitRel;
            StWaitRel: if (settle_q[1] && !sync_q && !step_lvl) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath: stage the ALU outputs in StEval (breaks the acc -> ALU loop),
    // commit or skip in StCommit.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            nzcv_q  <= 4'b0000;
            res_q   <= '0;
            flags_q <= 4'b0000;
            pass_q  <= 1'b0;
            exec_q  <= '0;
            skip_q  <= '0;
        end else if (state_q == StEval) begin
            res_q   <= i_res;
            flags_q <= i_nzcv;
            pass_q  <= cond_met(i_cond, nzcv_q);
        end else if (state_q == StCommit) begin
            if (pass_q) begin
                acc_q <= res_q;
                if (i_set_flags) nzcv_q <= flags_q;
                if (exec_q != CntMax) exec_q <= exec_q + CNT_W'(1);
            end else if (skip_q != CntMax) begin
                skip_q <= skip_q + CNT_W'(1);
            end
        end
    end

    assign o_acc       = acc_q;
    assign o_nzcv      = nzcv_q;
    assign o_cond_pass = pass_q;
    assign o_busy      = (state_q != StIdle);
    assign o_exec_cnt  = exec_q;
    assign o_skip_cnt  = skip_q;

endmodule

// File: tb/tb_alu_nzcv_writeback.sv
// Self-checking bench for alu_nzcv_writeback: directed cases plus randomized
// steps scored against a flag/condition reference model. A second instance
// with 2-bit counters exercises counter saturation.
module tb_alu_nzcv_writeback;

`ifdef STEP_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       i_step;
    logic [3:0] i_cond;
    logic       i_set_flags;
    logic [3:0] i_res;
    logic [3:0] i_nzcv;

    logic [3:0] o_acc, o_nzcv, s_acc, s_nzcv;
    logic       o_cond_pass, o_busy, s_cond_pass, s_busy;
    logic [7:0] o_exec_cnt, o_skip_cnt;
    logic [1:0] s_exec_cnt, s_skip_cnt;

    int errors = 0;
    int checks = 0;

    // Reference state.
    logic [3:0] m_acc, m_nzcv;
    logic       m_pass;
    int         m_exec, m_skip;

    always #5 clk = ~clk;

    alu_nzcv_writeback #(.N(4), .CNT_W(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .i_step(i_step), .i_cond(i_cond),
        .i_set_flags(i_set_flags), .i_res(i_res), .i_nzcv(i_nzcv),
        .o_acc(o_acc), .o_nzcv(o_nzcv), .o_cond_pass(o_cond_pass), .o_busy(o_busy),
        .o_exec_cnt(o_exec_cnt), .o_skip_cnt(o_skip_cnt)
    );

    alu_nzcv_writeback #(.N(4), .CNT_W(2), .DEBOUNCE_CYCLES(4)) dut_sat (
        .clk(clk), .rst(rst), .i_step(i_step), .i_cond(i_cond),
        .i_set_flags(i_set_flags), .i_res(i_res), .i_nzcv(i_nzcv),
        .o_acc(s_acc), .o_nzcv(s_nzcv), .o_cond_pass(s_cond_pass), .o_busy(s_busy),
        .o_exec_cnt(s_exec_cnt), .o_skip_cnt(s_skip_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ARM conditions come in complementary pairs: even code = predicate,
    // odd code = its negation; 1111 never passes.
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_acc = 4'h0; m_nzcv = 4'h0; m_pass = 1'b0; m_exec = 0; m_skip = 0;
    endtask

    task automatic model_step(input logic [3:0] c, input logic s, input logic [3:0] r,
                              input logic [3:0] f);
        m_pass = ref_cond(c, m_nzcv);
        if (m_pass) begin
            m_acc = r;
            if (s) m_nzcv = f;
            m_exec++;
        end else begin
            m_skip++;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "/acc"}, 32'(o_acc), 32'(m_acc));
        check_eq({tag, "/nzcv"}, 32'(o_nzcv), 32'(m_nzcv));
        check_eq({tag, "/pass"}, 32'(o_cond_pass), 32'(m_pass));
        check_eq({tag, "/exec"}, 32'(o_exec_cnt), 32'(sat(m_exec, 8)));
        check_eq({tag, "/skip"}, 32'(o_skip_cnt), 32'(sat(m_skip, 8)));
        check_eq({tag, "/sat_exec"}, 32'(s_exec_cnt), 32'(sat(m_exec, 2)));
        check_eq({tag, "/sat_skip"}, 32'(s_skip_cnt), 32'(sat(m_skip, 2)));
        check_eq({tag, "/sat_acc"}, 32'(s_acc), 32'(m_acc));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_busy && n < 60 + 2 * DB) begin
            tick(1);
            n++;
        end
        check_eq({tag, "/idle"}, 32'(o_busy), 32'(0));
    endtask

    task automatic press();
        i_step = 1'b1;
        tick(6 + DB);
        i_step = 1'b0;
    endtask

    task automatic run_step(input string tag, input logic [3:0] c, input logic s,
                            input logic [3:0] r, input logic [3:0] f);
        i_cond = c; i_set_flags = s; i_res = r; i_nzcv = f;
        press();
        wait_idle(tag);
        model_step(c, s, r, f);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; i_step = 1'b1; i_cond = 4'hE; i_set_flags = 1'b1;
        i_res = 4'h7; i_nzcv = 4'h0;
        model_reset();
        tick(4);
        check_eq("rst/acc", 32'(o_acc), 32'(0));
        check_eq("rst/nzcv", 32'(o_nzcv), 32'(0));
        check_eq("rst/pass", 32'(o_cond_pass), 32'(0));
        check_eq("rst/exec", 32'(o_exec_cnt), 32'(0));
        check_eq("rst/skip", 32'(o_skip_cnt), 32'(0));
        check_eq("rst/busy", 32'(o_busy), 32'(1));

        // Key held through reset must not produce a step.
        rst = 1'b0;
        tick(15 + DB);
        check_eq("hold/exec", 32'(o_exec_cnt), 32'(0));
        check_eq("hold/busy", 32'(o_busy), 32'(1));
        i_step = 1'b0;
        wait_idle("hold");
        check_eq("hold/exec_after", 32'(o_exec_cnt), 32'(0));

        // Latency: key up just after edge p0, acc changes at p(5+DB).
        i_step = 1'b1;
        tick(4 + DB);
        check_eq("lat/acc_pre", 32'(o_acc), 32'(0));
        check_eq("lat/pass", 32'(o_cond_pass), 32'(1));
        check_eq("lat/busy", 32'(o_busy), 32'(1));
        tick(1);
        check_eq("lat/acc", 32'(o_acc), 32'(7));
        check_eq("lat/exec", 32'(o_exec_cnt), 32'(1));
        tick(4);
        i_step = 1'b0;
        wait_idle("lat");
        model_step(4'hE, 1'b1, 4'h7, 4'h0);
        check_all("lat");

        // Z set: NE skips, EQ commits.
        run_step("setz", 4'hE, 1'b1, 4'h7, 4'b0100);
        run_step("ne", 4'h1, 1'b0, 4'h3, 4'h0);
        check_eq("ne/acc_const", 32'(o_acc), 32'(7));
        check_eq("ne/pass_const", 32'(o_cond_pass), 32'(0));
        run_step("eq", 4'h0, 1'b0, 4'h3, 4'h0);
        check_eq("eq/acc_const", 32'(o_acc), 32'(3));

        // set_flags gating.
        run_step("noset", 4'hE, 1'b0, 4'h9, 4'b1001);
        check_eq("noset/nzcv_const", 32'(o_nzcv), 32'(4'b0100));
        run_step("set", 4'hE, 1'b1, 4'hA, 4'b1001);
        check_eq("set/nzcv_const", 32'(o_nzcv), 32'(4'b1001));
        check_eq("sat/exec_const", 32'(s_exec_cnt), 32'(3));

        // GE / LT.
        run_step("ge_nv", 4'hA, 1'b0, 4'h1, 4'h0);
        run_step("lt_nv", 4'hB, 1'b0, 4'h2, 4'h0);
        run_step("set_n", 4'hE, 1'b1, 4'h4, 4'b1000);
        run_step("ge_n", 4'hA, 1'b0, 4'h5, 4'h0);
        run_step("lt_n", 4'hB, 1'b0, 4'h6, 4'h0);

        // NV never passes.
        for (int f = 0; f < 16; f++) begin
            run_step("nv_set", 4'hE, 1'b1, 4'(f), 4'(f));
            run_step("nv", 4'hF, 1'b1, 4'(~f), 4'(~f));
            check_eq("nv/pass_const", 32'(o_cond_pass), 32'(0));
        end

        // Short release and re-press during EVAL/COMMIT is one step only.
        i_cond = 4'hE; i_set_flags = 1'b0; i_res = 4'hC; i_nzcv = 4'h0;
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
        tick(1);
        i_step = 1'b1;
        tick(10 + DB);
        i_step = 1'b0;
        wait_idle("bounce");
        model_step(4'hE, 1'b0, 4'hC, 4'h0);
        check_all("bounce");

`ifdef STEP_DEBOUNCE_EN
        // 3-cycle glitch filtered, 4-cycle press accepted.
        i_res = 4'hD;
        i_step = 1'b1;
        tick(3);
        i_step = 1'b0;
        tick(12);
        check_eq("glitch/busy", 32'(o_busy), 32'(0));
        check_all("glitch");
        i_step = 1'b1;
        tick(4);
        i_step = 1'b0;
        tick(3);
        wait_idle("db4");
        model_step(4'hE, 1'b0, 4'hD, 4'h0);
        check_all("db4");
`endif

        // Randomized steps.
        for (int i = 0; i < 40; i++) begin
            run_step("rand", 4'($urandom_range(15)), 1'($urandom_range(1)),
                     4'($urandom_range(15)), 4'($urandom_range(15)));
        end

        // Reset during EVAL aborts the step.
        i_cond = 4'hE; i_set_flags = 1'b1; i_res = 4'hB; i_nzcv = 4'hF;
        i_step = 1'b1;
        tick(3 + DB);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
        tick(3);
        check_all("midrst");
        i_step = 1'b0;
        wait_idle("midrst");
        check_all("midrst_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
